// File: rtl/multdiv_pkg.sv
// multdiv_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - MIPS Funct codes the unit decodes for itself
//   - FSM state encoding (IDLE -> RUN -> FIX -> IDLE)
package multdiv_pkg;

    localparam logic [5:0] FUNCT_MULT  = 6'd24;
    localparam logic [5:0] FUNCT_MULTU = 6'd25;
    localparam logic [5:0] FUNCT_DIV   = 6'd26;
    localparam logic [5:0] FUNCT_DIVU  = 6'd27;
    localparam logic [5:0] FUNCT_MTHI  = 6'd17;
    localparam logic [5:0] FUNCT_MTLO  = 6'd19;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_e;

endpackage

// File: rtl/multdiv_signfix.sv
// multdiv_signfix
// Combinational sign handling for the multiply/divide unit.
//   Accept side: turns the raw operands into magnitudes for the unsigned
//   iterative core and works out the result signs.
//   FIX side:    applies the latched signs to product, quotient, remainder.
// Ports:
//   opA_i, opB_i     raw operands (WIDTH)
//   signedOp_i       1 for mult/div, 0 for multu/divu
//   magA_o, magB_o   operand magnitudes (raw values for unsigned ops)
//   negRes_o         product/quotient must be negated (operand signs differ)
//   negRem_o         remainder must be negated (dividend negative)
//   negResQ_i        latched negRes, used in FIX
//   negRemQ_i        latched negRem, used in FIX
//   prod_i           unsigned 2*WIDTH product of the magnitudes
//   quot_i, rem_i    unsigned quotient / remainder of the magnitudes
//   prodFix_o, quotFix_o, remFix_o   sign-corrected results
module multdiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   opA_i,
    input  logic [WIDTH-1:0]   opB_i,
    input  logic               signedOp_i,
    output logic [WIDTH-1:0]   magA_o,
    output logic [WIDTH-1:0]   magB_o,
    output logic               negRes_o,
    output logic               negRem_o,
    input  logic               negResQ_i,
    input  logic               negRemQ_i,
    input  logic [2*WIDTH-1:0] prod_i,
    input  logic [WIDTH-1:0]   quot_i,
    input  logic [WIDTH-1:0]   rem_i,
    output logic [2*WIDTH-1:0] prodFix_o,
    output logic [WIDTH-1:0]   quotFix_o,
    output logic [WIDTH-1:0]   remFix_o
);

    logic negA;
    logic negB;

    // The most-negative value maps onto itself under negation, which read
    // as unsigned is exactly its magnitude, so no extra bit is needed.
    always_comb begin
        negA     = signedOp_i & opA_i[WIDTH-1];
        negB     = signedOp_i & opB_i[WIDTH-1];
        magA_o   = negA ? -opA_i : opA_i;
        magB_o   = negB ? -opB_i : opB_i;
        negRes_o = negA ^ negB;
        negRem_o = negA;
    end

    // Remainder follows the dividend, product and quotient follow the
    // xor of the operand signs.
    always_comb begin
        prodFix_o = negResQ_i ? -prod_i : prod_i;
        quotFix_o = negResQ_i ? -quot_i : quot_i;
        remFix_o  = negRemQ_i ? -rem_i  : rem_i;
    end

endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit
// Iterative multiply/divide unit with its own HI/LO pair for the
// multi-cycle MIPS datapath. Executes mult/multu/div/divu in WIDTH+1
// edges (shift-add multiply, restoring divide) and services mthi/mtlo
// with no stall. The control FSM stalls on busy.
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous, active-low; clears all state
//   start   request, sampled only in IDLE
//   Funct   MIPS funct field (24/25/26/27 mult/multu/div/divu, 17 mthi, 19 mtlo)
//   OpA     multiplicand / dividend / mthi-mtlo source
//   OpB     multiplier / divisor
//   busy    operation in flight
//   done    one-cycle pulse after HI/LO are written by mult/div
//   Hi, Lo  HI/LO registers
// Configuration macro:
//   MULTDIV_FAST_MULT_EN  mult/multu use a single-cycle combinational
//                         multiply and finish at E1; divides unchanged.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e               stateQ;
    logic [CNT_W-1:0]     cntQ;
    logic                 isDivQ;
    logic                 negResQ;
    logic                 negRemQ;
    logic                 busyQ;
    logic                 doneQ;
    logic [WIDTH-1:0]     hiQ;
    logic [WIDTH-1:0]     loQ;
    logic [WIDTH-1:0]     mcandQ;
    logic [2*WIDTH-1:0]   accQ;
    logic [WIDTH-1:0]     remQ;

    logic                 isMulOp;
    logic                 isDivOp;
    logic                 signedOp;
    logic [WIDTH-1:0]     magA;
    logic [WIDTH-1:0]     magB;
    logic                 negRes;
    logic                 negRem;
    logic [2*WIDTH-1:0]   prodFix;
    logic [WIDTH-1:0]     quotFix;
    logic [WIDTH-1:0]     remFix;

    logic [WIDTH:0]       mulSum;
    logic [2*WIDTH-1:0]   mulNext;
    logic [WIDTH:0]       divShift;
    logic [WIDTH:0]       divDiff;
    logic [WIDTH-1:0]     divRemNext;
    logic [WIDTH-1:0]     divQuotNext;

`ifdef MULTDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0]   fastProd;

    always_comb begin
        fastProd = {{WIDTH{1'b0}}, magA} * {{WIDTH{1'b0}}, magB};
    end
`endif

    always_comb begin
        isMulOp  = (Funct == FUNCT_MULT) || (Funct == FUNCT_MULTU);
        isDivOp  = (Funct == FUNCT_DIV)  || (Funct == FUNCT_DIVU);
        signedOp = (Funct == FUNCT_MULT) || (Funct == FUNCT_DIV);
    end

    multdiv_signfix #(
        .WIDTH(WIDTH)
    ) u_signfix (
        .opA_i     (OpA),
        .opB_i     (OpB),
        .signedOp_i(signedOp),
        .magA_o    (magA),
        .magB_o    (magB),
        .negRes_o  (negRes),
        .negRem_o  (negRem),
        .negResQ_i (negResQ),
        .negRemQ_i (negRemQ),
        .prod_i    (accQ),
        .quot_i    (accQ[WIDTH-1:0]),
        .rem_i     (remQ),
        .prodFix_o (prodFix),
        .quotFix_o (quotFix),
        .remFix_o  (remFix)
    );

    // One iteration step of each algorithm.
    // Multiply: accQ = {partial sum, remaining multiplier bits}; add the
    // multiplicand when the current multiplier bit is set, shift right.
    // Divide: the remainder shifted left with the next dividend bit forms
    // the WIDTH+1-bit partial remainder; keep the difference when it is
    // non-negative. A zero divisor always "fits", so the quotient becomes
    // all ones and the remainder the dividend without a special case.
    always_comb begin
        mulSum      = {1'b0, accQ[2*WIDTH-1:WIDTH]}
                    + {1'b0, (accQ[0] ? mcandQ : {WIDTH{1'b0}})};
        mulNext     = {mulSum, accQ[WIDTH-1:1]};
        divShift    = {remQ, accQ[WIDTH-1]};
        divDiff     = divShift - {1'b0, mcandQ};
        divRemNext  = divDiff[WIDTH] ? divShift[WIDTH-1:0] : divDiff[WIDTH-1:0];
        divQuotNext = {accQ[WIDTH-2:0], ~divDiff[WIDTH]};
    end

    // Control FSM and datapath registers. Hi/Lo only move on the FIX edge
    // or on an mthi/mtlo accepted in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ  <= IDLE;
            cntQ    <= '0;
            isDivQ  <= 1'b0;
            negResQ <= 1'b0;
            negRemQ <= 1'b0;
            busyQ   <= 1'b0;
            doneQ   <= 1'b0;
            hiQ     <= '0;
            loQ     <= '0;
            mcandQ  <= '0;
            accQ    <= '0;
            remQ    <= '0;
        end else begin
            doneQ <= 1'b0;
            case (stateQ)
                IDLE: begin
                    if (start) begin
                        if (Funct == FUNCT_MTHI) begin
                            hiQ <= OpA;
                        end else if (Funct == FUNCT_MTLO) begin
                            loQ <= OpA;
                        end else if (isMulOp || isDivOp) begin
                            isDivQ  <= isDivOp;
                            negResQ <= negRes;
                            negRemQ <= negRem;
                            cntQ    <= '0;
                            busyQ   <= 1'b1;
                            remQ    <= '0;
                            mcandQ  <= isDivOp ? magB : magA;
`ifdef MULTDIV_FAST_MULT_EN
                            if (isMulOp) begin
                                accQ   <= fastProd;
                                stateQ <= FIX;
                            end else begin
                                accQ   <= {{WIDTH{1'b0}}, magA};
                                stateQ <= RUN;
                            end
`else
                            accQ   <= {{WIDTH{1'b0}}, (isDivOp ? magA : magB)};
                            stateQ <= RUN;
`endif
                        end
                    end
                end
                RUN: begin
                    if (isDivQ) begin
                        remQ             <= divRemNext;
                        accQ[WIDTH-1:0]  <= divQuotNext;
                    end else begin
                        accQ <= mulNext;
                    end
                    if (cntQ == CNT_W'(WIDTH - 1)) begin
                        stateQ <= FIX;
                    end else begin
                        cntQ <= cntQ + 1'b1;
                    end
                end
                FIX: begin
                    hiQ    <= isDivQ ? remFix  : prodFix[2*WIDTH-1:WIDTH];
                    loQ    <= isDivQ ? quotFix : prodFix[WIDTH-1:0];
                    doneQ  <= 1'b1;
                    busyQ  <= 1'b0;
                    stateQ <= IDLE;
                end
                default: begin
                    stateQ <= IDLE;
                end
            endcase
        end
    end

    assign busy = busyQ;
    assign done = doneQ;
    assign Hi   = hiQ;
    assign Lo   = loQ;

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed-vector testbench for multdiv_unit (WIDTH = 32).
// Expected values are hand-computed; latency expectations follow the
// MULTDIV_FAST_MULT_EN setting used for the build.
module tb_multdiv_unit;

   localparam int WIDTH = 32;
   localparam logic [5:0] F_MULT  = 6'd24;
   localparam logic [5:0] F_MULTU = 6'd25;
   localparam logic [5:0] F_DIV   = 6'd26;
   localparam logic [5:0] F_DIVU  = 6'd27;
   localparam logic [5:0] F_MTHI  = 6'd17;
   localparam logic [5:0] F_MTLO  = 6'd19;
   localparam int DivLat = WIDTH + 1;
`ifdef MULTDIV_FAST_MULT_EN
   localparam int MulLat = 1;
`else
   localparam int MulLat = WIDTH + 1;
`endif

   logic             clock;
   logic             resetN;
   logic             start;
   logic [5:0]       funct;
   logic [WIDTH-1:0] opA;
   logic [WIDTH-1:0] opB;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   int checkCount = 0;
   int errorCount = 0;
   int latency;

   multdiv_unit #(
      .WIDTH(WIDTH)
   ) dut (
      .clk  (clock),
      .reset(resetN),
      .start(start),
      .Funct(funct),
      .OpA  (opA),
      .OpB  (opB),
      .busy (busy),
      .done (done),
      .Hi   (hi),
      .Lo   (lo)
   );

   // Free-running clock, 10 time units per period
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Compares one observed value against its expectation and tallies it
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Presents a request for one accept edge (E0), returns #1 after it
   task automatic applyStimulus(input logic [5:0] f, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b);
      start = 1'b1;
      funct = f;
      opA   = a;
      opB   = b;
      @(posedge clock);
      #1;
      start = 1'b0;
      funct = 6'd0;
   endtask

   // Counts edges until done is seen; -1 if it never arrives
   task automatic waitDone(output int lat);
      lat = -1;
      for (int n = 1; n <= 200; n++) begin
         @(posedge clock);
         #1;
         if (done === 1'b1) begin
            lat = n;
            break;
         end
      end
   endtask

   // Advances one cycle and returns #1 after the edge
   task automatic stepCycle();
      @(posedge clock);
      #1;
   endtask

   // Hard stop in case something blocks outside the bounded waits
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Main directed sequence
   initial begin
      resetN = 1'b0;
      start  = 1'b0;
      funct  = 6'd0;
      opA    = '0;
      opB    = '0;
      repeat (3) stepCycle();
      checkOutput("reset busy", 64'(busy), 64'd0);
      checkOutput("reset done", 64'(done), 64'd0);
      checkOutput("reset hi",   64'(hi),   64'd0);
      checkOutput("reset lo",   64'(lo),   64'd0);
      resetN = 1'b1;
      stepCycle();

      // mult 7 * -3 = -21
      applyStimulus(F_MULT, 32'd7, 32'hFFFF_FFFD);
      checkOutput("mult busy", 64'(busy), 64'd1);
      checkOutput("mult lo held", 64'(lo), 64'd0);
      waitDone(latency);
      checkOutput("mult latency", 64'(latency), 64'(MulLat));
      checkOutput("mult hi", 64'(hi), 64'hFFFF_FFFF);
      checkOutput("mult lo", 64'(lo), 64'hFFFF_FFEB);
      checkOutput("mult busy end", 64'(busy), 64'd0);
      stepCycle();
      checkOutput("mult done pulse", 64'(done), 64'd0);

      // multu 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
      applyStimulus(F_MULTU, 32'hFFFF_FFFF, 32'd2);
      waitDone(latency);
      checkOutput("multu latency", 64'(latency), 64'(MulLat));
      checkOutput("multu hi", 64'(hi), 64'h0000_0001);
      checkOutput("multu lo", 64'(lo), 64'hFFFF_FFFE);
      stepCycle();

      // div -7 / 2 = -3 rem -1
      applyStimulus(F_DIV, 32'hFFFF_FFF9, 32'd2);
      waitDone(latency);
      checkOutput("div latency", 64'(latency), 64'(DivLat));
      checkOutput("div lo", 64'(lo), 64'hFFFF_FFFD);
      checkOutput("div hi", 64'(hi), 64'hFFFF_FFFF);

      // Back-to-back: issued while done is high; signed overflow case
      applyStimulus(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      checkOutput("b2b accepted busy", 64'(busy), 64'd1);
      checkOutput("b2b done cleared", 64'(done), 64'd0);
      waitDone(latency);
      checkOutput("divovf latency", 64'(latency), 64'(DivLat));
      checkOutput("divovf lo", 64'(lo), 64'h8000_0000);
      checkOutput("divovf hi", 64'(hi), 64'd0);
      stepCycle();

      // divu by zero
      applyStimulus(F_DIVU, 32'd100, 32'd0);
      waitDone(latency);
      checkOutput("div0 latency", 64'(latency), 64'(DivLat));
      checkOutput("div0 lo", 64'(lo), 64'hFFFF_FFFF);
      checkOutput("div0 hi", 64'(hi), 64'h0000_0064);
      stepCycle();

      // divu 1000 / 7 = 142 rem 6, with an mtlo attempt during RUN (edge E5)
      applyStimulus(F_DIVU, 32'd1000, 32'd7);
      repeat (4) stepCycle();
      start = 1'b1;
      funct = F_MTLO;
      opA   = 32'h0000_1234;
      stepCycle();
      start = 1'b0;
      funct = 6'd0;
      checkOutput("run mtlo ignored", 64'(lo), 64'hFFFF_FFFF);
      checkOutput("run hi held", 64'(hi), 64'h0000_0064);
      checkOutput("run busy", 64'(busy), 64'd1);
      waitDone(latency);
      checkOutput("divu remaining latency", 64'(latency), 64'(DivLat - 5));
      checkOutput("divu lo", 64'(lo), 64'd142);
      checkOutput("divu hi", 64'(hi), 64'd6);
      stepCycle();

      // mthi in IDLE: immediate, no busy, no done
      applyStimulus(F_MTHI, 32'h0000_ABCD, 32'd0);
      checkOutput("mthi hi", 64'(hi), 64'h0000_ABCD);
      checkOutput("mthi lo kept", 64'(lo), 64'd142);
      checkOutput("mthi busy", 64'(busy), 64'd0);
      checkOutput("mthi done", 64'(done), 64'd0);

      // Unknown Funct: no effect
      applyStimulus(6'd32, 32'h5555_5555, 32'd1);
      checkOutput("badfunct busy", 64'(busy), 64'd0);
      checkOutput("badfunct hi", 64'(hi), 64'h0000_ABCD);
      checkOutput("badfunct lo", 64'(lo), 64'd142);

      // Reset in the middle of RUN
      applyStimulus(F_DIVU, 32'd1000, 32'd7);
      repeat (10) stepCycle();
      checkOutput("prereset busy", 64'(busy), 64'd1);
      resetN = 1'b0;
      #1;
      checkOutput("midreset busy", 64'(busy), 64'd0);
      checkOutput("midreset hi", 64'(hi), 64'd0);
      checkOutput("midreset lo", 64'(lo), 64'd0);
      checkOutput("midreset done", 64'(done), 64'd0);
      repeat (2) stepCycle();
      resetN = 1'b1;
      stepCycle();
      checkOutput("postreset done", 64'(done), 64'd0);

      // Fresh multiply after reset release: 3 * 5
      applyStimulus(F_MULT, 32'd3, 32'd5);
      waitDone(latency);
      checkOutput("postreset mult latency", 64'(latency), 64'(MulLat));
      checkOutput("postreset mult lo", 64'(lo), 64'd15);
      checkOutput("postreset mult hi", 64'(hi), 64'd0);
      stepCycle();

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
